fixed_point_mul_pipe: RTL and testbench

FIXED_POINT_MUL_PIPE -- requirements
Module: fixed_point_mul_pipe

---
 rtl/fixed_point_mul_pipe.sv | 122 ++++++++++++
 tb/tb_fixed_point_mul_pipe.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_point_mul_pipe.sv
// Three-stage signed fixed-point multiplier with per-transaction rounding and
// saturation modes, a single global stall and a sticky overflow flag.
module fixed_point_mul_pipe #(
    parameter int WIDTH  = 16,
    parameter int FRAC_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic             rnd,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             ovf_sticky,
    input  logic             ovf_clear
);

    localparam int PW = 2 * WIDTH;
    localparam int QW = 2 * WIDTH + 1;

    localparam logic signed [QW-1:0] RND_C = {{(QW-1){1'b0}}, 1'b1} << (FRAC_W - 1);
    localparam logic signed [QW-1:0] Q_MAX = {{(WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [QW-1:0] Q_MIN = {{(WIDTH+2){1'b1}}, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0]     MAX_W = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0]     MIN_W = {1'b1, {(WIDTH-1){1'b0}}};

    logic advance;

    logic                    v1, rnd1, sat1;
    logic signed [WIDTH-1:0] a1, b1;

    logic                 v2, rnd2, sat2;
    logic signed [PW-1:0] prod2;

    logic signed [PW-1:0] prod_c;
    logic signed [QW-1:0] p_c;
    logic signed [QW-1:0] q_c;
    logic                 ovf_c;
    logic [WIDTH-1:0]     res_c;

    // One advance signal for the whole pipe: a full output stage that is not
    // being taken freezes every stage, so nothing is ever overwritten.
    assign advance  = out_ready | ~out_valid;
    assign in_ready = advance;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            a1   <= '0;
            b1   <= '0;
            rnd1 <= 1'b0;
            sat1 <= 1'b0;
        end else if (advance) begin
            v1   <= in_valid;
            a1   <= op1;
            b1   <= op2;
            rnd1 <= rnd;
            sat1 <= sat;
        end
    end

    // Operands are sign-extended before the multiply so the full product fits.
    assign prod_c = PW'(a1) * PW'(b1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2    <= 1'b0;
            prod2 <= '0;
            rnd2  <= 1'b0;
            sat2  <= 1'b0;
        end else if (advance) begin
            v2    <= v1;
            prod2 <= prod_c;
            rnd2  <= rnd1;
            sat2  <= sat1;
        end
    end

    // The extra intermediate bit keeps the rounding add from wrapping.
    always_comb begin
        p_c = QW'(prod2);
        if (rnd2) begin
            p_c = p_c + RND_C;
        end
        q_c   = p_c >>> FRAC_W;
        ovf_c = (q_c > Q_MAX) || (q_c < Q_MIN);
        if (ovf_c && sat2) begin
            res_c = q_c[QW-1] ? MIN_W : MAX_W;
        end else begin
            res_c = q_c[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            overflow  <= 1'b0;
        end else if (advance) begin
            out_valid <= v2;
            result    <= res_c;
            overflow  <= ovf_c;
        end
    end

    // A delivered overflow beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
        end else if (out_valid && out_ready && overflow) begin
            ovf_sticky <= 1'b1;
        end else if (ovf_clear) begin
            ovf_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fixed_point_mul_pipe.sv
// Self-checking bench for fixed_point_mul_pipe (WIDTH=16, FRAC_W=8): directed
// vectors, stall/stream scoreboard against an arithmetic model, reset flush.
module tb_fixed_point_mul_pipe;

    localparam int W = 16;
    localparam int F = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op1, op2;
    logic         rnd, sat;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         overflow;
    logic         ovf_sticky;
    logic         ovf_clear;

    int tests = 0;
    int fails = 0;

    logic [16:0] exp_q[$];

    fixed_point_mul_pipe #(.WIDTH(W), .FRAC_W(F)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op1        (op1),
        .op2        (op2),
        .rnd        (rnd),
        .sat        (sat),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .overflow   (overflow),
        .ovf_sticky (ovf_sticky),
        .ovf_clear  (ovf_clear)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Plain integer arithmetic: exact product, optional +0.5 LSB, floor shift.
    function automatic logic [16:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic r, input logic s);
        longint p, q;
        logic [W-1:0] res;
        logic ov;
        p = longint'($signed(a)) * longint'($signed(b));
        if (r) p = p + (longint'(1) << (F - 1));
        q = p >>> F;
        ov = (q > 32767) || (q < -32768);
        if (ov && s) res = (q > 0) ? 16'h7FFF : 16'h8000;
        else         res = q[W-1:0];
        return {ov, res};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single op with out_ready=1; checks latency, value, and that nothing repeats.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic r, input logic s, input logic [W-1:0] exp_r,
                          input logic exp_o, input logic clr_at_out);
        int lat;
        op1 = a; op2 = b; rnd = r; sat = s; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 8) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd3);
        check({tag, "_result"}, 32'(result), 32'(exp_r));
        check({tag, "_overflow"}, 32'(overflow), 32'(exp_o));
        ovf_clear = clr_at_out;
        tick();
        ovf_clear = 1'b0;
        check({tag, "_no_dup"}, 32'(out_valid), 32'd0);
    endtask

    // mode 0: 4 back-to-back ops with out_ready low in cycles 4 and 5.
    // mode 1: random in_valid / out_ready traffic.
    task automatic stream(input string tag, input int n, input int mode);
        int sent = 0, got = 0, cyc = 0;
        logic have = 1'b0, hold = 1'b0, held_o = 1'b0;
        logic [W-1:0] ca = '0, cb = '0, held_r = '0;
        logic cr = 1'b0, cs = 1'b0;
        logic [16:0] e;
        exp_q.delete();
        while (got < n && cyc < n * 8 + 50) begin
            if (!have) begin
                ca = 16'($urandom); cb = 16'($urandom);
                cr = 1'($urandom); cs = 1'($urandom);
                have = 1'b1;
            end
            op1 = ca; op2 = cb; rnd = cr; sat = cs;
            in_valid  = (sent < n) && (mode == 0 || $urandom_range(0, 3) != 0);
            out_ready = (mode == 0) ? !(cyc == 4 || cyc == 5) : ($urandom_range(0, 2) != 0);
            #1;
            if (mode == 0 && !out_ready) begin
                check({tag, "_stall_in_ready"}, 32'(in_ready), 32'd0);
                check({tag, "_stall_out_valid"}, 32'(out_valid), 32'd1);
            end
            if (hold) begin
                check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
                check({tag, "_hold_result"}, 32'(result), 32'(held_r));
                check({tag, "_hold_overflow"}, 32'(overflow), 32'(held_o));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check({tag, "_spurious_out"}, 32'(out_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check({tag, "_result"}, 32'(result), 32'(e[15:0]));
                    check({tag, "_overflow"}, 32'(overflow), 32'(e[16]));
                end
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(ca, cb, cr, cs));
                sent++;
                have = 1'b0;
            end
            hold   = out_valid && !out_ready;
            held_r = result;
            held_o = overflow;
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check({tag, "_delivered"}, 32'(got), 32'(n));
        tick();
        tick();
        tick();
        tick();
        check({tag, "_drained"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int extra;
        rst_n = 1'b0; in_valid = 1'b0; op1 = '0; op2 = '0; rnd = 1'b0; sat = 1'b0;
        out_ready = 1'b1; ovf_clear = 1'b0;
        #3;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_result", 32'(result), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_sticky", 32'(ovf_sticky), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        run_op("basic",    16'h0180, 16'h0200, 1'b0, 1'b1, 16'h0300, 1'b0, 1'b0);
        run_op("negative", 16'hFF00, 16'h0180, 1'b0, 1'b1, 16'hFE80, 1'b0, 1'b0);
        run_op("trunc",    16'h0001, 16'h0080, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
        run_op("round",    16'h0001, 16'h0080, 1'b1, 1'b1, 16'h0001, 1'b0, 1'b0);
        run_op("trunc_neg",16'hFFFF, 16'h0080, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);
        check("sticky_idle", 32'(ovf_sticky), 32'd0);
        run_op("sat_pos",  16'h7F00, 16'h0200, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b0);
        check("sticky_set", 32'(ovf_sticky), 32'd1);
        run_op("wrap_pos", 16'h7F00, 16'h0200, 1'b0, 1'b0, 16'hFE00, 1'b1, 1'b0);
        check("sticky_hold", 32'(ovf_sticky), 32'd1);
        ovf_clear = 1'b1;
        tick();
        ovf_clear = 1'b0;
        check("sticky_clear", 32'(ovf_sticky), 32'd0);
        run_op("min_sq",   16'h8000, 16'h8000, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        check("sticky_set_wins", 32'(ovf_sticky), 32'd1);
        ovf_clear = 1'b1;
        tick();
        ovf_clear = 1'b0;
        run_op("min_one",  16'h8000, 16'h0100, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b0);
        run_op("sat_neg",  16'h8000, 16'h7FFF, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b0);
        check("sticky_after_neg", 32'(ovf_sticky), 32'd1);

        stream("stall4", 4, 0);
        stream("rand", 200, 1);

        // Reset with two operations in flight.
        op1 = 16'h0100; op2 = 16'h0100; rnd = 1'b0; sat = 1'b1;
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        op1 = 16'h0200;
        tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        check("flush_sticky", 32'(ovf_sticky), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid) extra++;
        end
        check("flush_no_output", 32'(extra), 32'd0);
        run_op("post_rst", 16'h0300, 16'hFE00, 1'b1, 1'b0, 16'hFA00, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
